// File: rtl/m_bus_master.sv
// Load/store bus master: turns one pipeline memory op into a single bus access.
// It handles alignment checks, lane steering of store data, load extension and an access timeout.
module m_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r;
  logic [2:0]      op_type_r;
  logic [1:0]      op_lane_r;
  logic [CW-1:0]   cnt_r;

  // Width class of an op type: 2 word, 1 halfword, 0 byte; 5-7 fall back to word.
  function automatic logic [1:0] width_of(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: width_of = 2'd1;
      3'd3, 3'd4: width_of = 2'd0;
      default:    width_of = 2'd2;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] t, input logic [1:0] a);
    case (width_of(t))
      2'd2:    is_aligned = (a == 2'b00);
      2'd1:    is_aligned = (a[0] == 1'b0);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  // Loads always fetch the whole word; stores enable only the touched lanes.
  function automatic logic [3:0] be_of(input logic we, input logic [2:0] t, input logic [1:0] a);
    if (!we) begin
      be_of = 4'b1111;
    end else begin
      case (width_of(t))
        2'd1:    be_of = a[1] ? 4'b1100 : 4'b0011;
        2'd0:    be_of = 4'b0001 << a;
        default: be_of = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] t, input logic [31:0] d);
    case (width_of(t))
      2'd1:    wdata_of = {2{d[15:0]}};
      2'd0:    wdata_of = {4{d[7:0]}};
      default: wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] byte_w;
    logic [31:0] half_w;
    byte_w = rd >> {a, 3'b000};
    half_w = rd >> {a[1], 4'b0000};
    case (t)
      3'd1:    load_ext = {16'h0000, half_w[15:0]};
      3'd2:    load_ext = {{16{half_w[15]}}, half_w[15:0]};
      3'd3:    load_ext = {24'h000000, byte_w[7:0]};
      3'd4:    load_ext = {{24{byte_w[7]}}, byte_w[7:0]};
      default: load_ext = rd;
    endcase
  endfunction

  // The pipeline must hold in the accepting cycle too, before the state has moved.
  assign stall = ((state_r == IDLE) && op_valid) || (state_r == REQ);

  // Access sequencer with all bus and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      op_type_r <= 3'd0;
      op_lane_r <= 2'd0;
      cnt_r     <= '0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      load_data <= 32'h0000_0000;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          done     <= 1'b0;
          addr_err <= 1'b0;
          bus_err  <= 1'b0;
          if (op_valid) begin
            op_type_r <= op_type;
            op_lane_r <= op_addr[1:0];
            bus_we    <= op_we;
            bus_addr  <= {op_addr[31:2], 2'b00};
            bus_be    <= be_of(op_we, op_type, op_addr[1:0]);
            bus_wdata <= wdata_of(op_type, op_wdata);
            load_data <= 32'h0000_0000;
            cnt_r     <= '0;
            if (is_aligned(op_type, op_addr[1:0])) begin
              state_r <= REQ;
              bus_req <= 1'b1;
            end else begin
              state_r  <= DONE;
              done     <= 1'b1;
              addr_err <= 1'b1;
            end
          end
        end
        REQ: begin
          // Ack takes priority over the timeout in the final counted cycle.
          if (bus_ack) begin
            state_r   <= DONE;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            load_data <= bus_we ? 32'h0000_0000 : load_ext(op_type_r, op_lane_r, bus_rdata);
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= DONE;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r  <= IDLE;
          done     <= 1'b0;
          addr_err <= 1'b0;
          bus_err  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          bus_req <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_bus_master.sv
// Directed bench for m_bus_master: loads, stores, misalignment, timeout, reset and back-to-back ops.
module tb_m_bus_master;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_we;
  logic [2:0]  op_type;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int n;

  m_bus_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_we(op_we), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall), .load_data(load_data),
    .done(done), .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d);
    op_valid = 1'b1;
    op_we    = we;
    op_type  = t;
    op_addr  = a;
    op_wdata = d;
  endtask

  // Load acked in its first REQ cycle, then checks the extended result.
  task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    set_op(1'b0, t, a, 32'h0);
    tick();
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
    bus_ack = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    op_valid = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_data"}, load_data, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_type = 3'd0;
    op_addr = 32'h0; op_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_errs", {30'd0, addr_err, bus_err}, 32'd0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", {28'd0, bus_be}, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    reset = 1'b0;
    tick();

    // Signed byte load, ack in second REQ cycle, done three cycles after acceptance.
    set_op(1'b0, 3'd4, 32'h0000_1003, 32'h0);
    #1;
    chk("lb_stall_accept", {31'd0, stall}, 32'd1);
    tick();
    chk("lb_req", {31'd0, bus_req}, 32'd1);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_be", {28'd0, bus_be}, 32'hF);
    chk("lb_we", {31'd0, bus_we}, 32'd0);
    chk("lb_stall_req", {31'd0, stall}, 32'd1);
    tick();
    chk("lb_req2", {31'd0, bus_req}, 32'd1);
    chk("lb_notdone", {31'd0, done}, 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'h8077_0000;
    tick();
    bus_ack = 1'b0;
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_req_drop", {31'd0, bus_req}, 32'd0);
    chk("lb_stall_done", {31'd0, stall}, 32'd0);
    chk("lb_errs", {30'd0, addr_err, bus_err}, 32'd0);
    op_valid = 1'b0;
    tick();
    chk("lb_done_pulse", {31'd0, done}, 32'd0);

    // Timeout: no ack, bus_req for 16 cycles then bus_err.
    set_op(1'b0, 3'd0, 32'h0000_3000, 32'h0);
    tick();
    n = 0;
    while (bus_req && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 32'd16);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_addr_err", {31'd0, addr_err}, 32'd0);
    chk("to_ldata", load_data, 32'h0);
    op_valid = 1'b0;
    tick();
    chk("to_err_clear", {31'd0, bus_err}, 32'd0);

    // Ack on the 16th REQ cycle wins over the timeout.
    set_op(1'b0, 3'd0, 32'h0000_4000, 32'h0);
    tick();
    repeat (15) tick();
    chk("ack16_req", {31'd0, bus_req}, 32'd1);
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFE_0001;
    tick();
    bus_ack = 1'b0;
    op_valid = 1'b0;
    chk("ack16_done", {31'd0, done}, 32'd1);
    chk("ack16_bus_err", {31'd0, bus_err}, 32'd0);
    chk("ack16_data", load_data, 32'hCAFE_0001);
    tick();

    // Store halfword to upper lane.
    set_op(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD);
    tick();
    chk("sh_we", {31'd0, bus_we}, 32'd1);
    chk("sh_be", {28'd0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_addr", bus_addr, 32'h0000_2000);
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    op_valid = 1'b0;
    chk("sh_done", {31'd0, done}, 32'd1);
    chk("sh_ldata", load_data, 32'h0);
    tick();

    // Store byte to lane 1.
    set_op(1'b1, 3'd3, 32'h0000_6001, 32'h0000_005A);
    tick();
    chk("sb_be", {28'd0, bus_be}, 32'h2);
    chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    op_valid = 1'b0;
    tick();

    // Misaligned word load: straight to DONE with addr_err, no bus request.
    set_op(1'b0, 3'd0, 32'h0000_0006, 32'h0);
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("mis_req", {31'd0, bus_req}, 32'd0);
    chk("mis_done", {31'd0, done}, 32'd1);
    chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
    chk("mis_stall_done", {31'd0, stall}, 32'd0);
    op_valid = 1'b0;
    tick();
    chk("mis_clear", {30'd0, done, addr_err}, 32'd0);
    chk("mis_noreq", {31'd0, bus_req}, 32'd0);

    // Extension variants.
    do_load("lhs", 3'd2, 32'h0000_5002, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu", 3'd1, 32'h0000_5000, 32'h1234_8765, 32'h0000_8765);
    do_load("lbu", 3'd3, 32'h0000_5001, 32'h0000_F000, 32'h0000_00F0);
    do_load("lw7", 3'd7, 32'h0000_5004, 32'h89AB_CDEF, 32'h89AB_CDEF);

    // Reset on the second REQ cycle, then a stray ack.
    set_op(1'b0, 3'd0, 32'h0000_8000, 32'h0);
    tick();
    tick();
    chk("rr_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    op_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("rr_req_drop", {31'd0, bus_req}, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'h1111_2222;
    tick();
    bus_ack = 1'b0;
    chk("rr_no_done", {31'd0, done}, 32'd0);
    tick();
    chk("rr_no_done2", {31'd0, done}, 32'd0);
    chk("rr_ldata", load_data, 32'h0);

    // Back-to-back loads with op_valid held throughout.
    set_op(1'b0, 3'd0, 32'h0000_7000, 32'h0);
    tick();
    chk("bb_addr1", bus_addr, 32'h0000_7000);
    bus_ack = 1'b1;
    bus_rdata = 32'h1111_1111;
    tick();
    bus_ack = 1'b0;
    chk("bb_done1", {31'd0, done}, 32'd1);
    chk("bb_stall_done", {31'd0, stall}, 32'd0);
    op_addr = 32'h0000_7104;
    tick();
    chk("bb_idle_req", {31'd0, bus_req}, 32'd0);
    chk("bb_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("bb_req2", {31'd0, bus_req}, 32'd1);
    chk("bb_addr2", bus_addr, 32'h0000_7104);
    bus_ack = 1'b1;
    bus_rdata = 32'h2222_2222;
    tick();
    bus_ack = 1'b0;
    op_valid = 1'b0;
    chk("bb_data2", load_data, 32'h2222_2222);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_bus_master.md
M_BUS_MASTER -- requirements
Module: m_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of REQ-state cycles without bus_ack before the access aborts.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 op_valid  input  1  SHALL mark a memory op from the pipeline, held stable while stall=1.
REQ-005 op_we  input  1  SHALL mark the op as a store (1) or a load (0).
REQ-006 op_type  input  3  SHALL give the access width: 0 word, 1 hword unsigned, 2 hword signed, 3 byte unsigned, 4 byte signed; 5-7 SHALL be treated as word.
REQ-007 op_addr  input  32  SHALL be the byte address.
REQ-008 op_wdata  input  32  SHALL be the store data, right-aligned.
REQ-009 stall  output  1  SHALL freeze the pipeline while the op is in flight.
REQ-010 load_data  output  32  SHALL carry the extended load result.
REQ-011 done  output  1  SHALL pulse for one cycle when the op completes.
REQ-012 addr_err, bus_err  output  1 each  SHALL flag a misaligned access or a timeout; both valid only while done=1.
REQ-013 bus_req, bus_we  output  1 each  SHALL carry the bus request and its write flag.
REQ-014 bus_addr  output  32  SHALL be the word-aligned address, with bits[1:0]=0.
REQ-015 bus_be  output  4  SHALL carry the byte enables.
REQ-016 bus_wdata  output  32  SHALL carry the lane-replicated store data.
REQ-017 bus_ack  input  1  SHALL be the responder's one-cycle completion strobe.
REQ-018 bus_rdata  input  32  SHALL be the responder's read word, valid with bus_ack.

Function
REQ-019 The block SHALL use three states: IDLE, REQ, DONE.
REQ-020 IDLE: when op_valid=1, the block SHALL latch op_we, op_type, op_addr and op_wdata; if the access is aligned it SHALL go to REQ, otherwise to DONE with addr_err set.
REQ-021 Alignment rules: word SHALL need addr[1:0]=0; hword SHALL need addr[0]=0; byte is always aligned.
REQ-022 stall SHALL equal (IDLE && op_valid) || REQ; it SHALL be 0 in DONE.
REQ-023 In DONE, op_valid SHALL be ignored; the next state SHALL be IDLE, so one op is accepted at most every 3 cycles.
REQ-024 bus_req SHALL be 1 exactly while in REQ; bus_we, bus_addr, bus_be and bus_wdata SHALL come from the latched op and stay stable throughout REQ.
REQ-025 bus_be SHALL be 1111 for word, 0011 or 1100 for hword (addr[1]=0 or 1), and 0001<<addr[1:0] for byte.
REQ-026 bus_wdata SHALL be the word itself, {2{wdata[15:0]}} for hword, or {4{wdata[7:0]}} for byte.
REQ-027 When bus_ack=1 in REQ, the block SHALL go to DONE; for a load, load_data SHALL be registered from bus_rdata by selecting the lane at addr[1:0] and then zero- or sign-extending per op_type.
REQ-028 bus_ack outside REQ SHALL be ignored.
REQ-029 Timeout counter: it SHALL clear on entry to REQ and increment each REQ cycle without ack; when it reaches TIMEOUT-1 without ack, the block SHALL go to DONE with bus_err=1 and load_data=0.
REQ-030 If ack arrives in the same cycle the counter reaches TIMEOUT-1, ack SHALL win and bus_err SHALL be 0.
REQ-031 For a store, load_data SHALL be 0 in DONE.
REQ-032 A misaligned op SHALL never assert bus_req.

Reset
REQ-033 On reset the block SHALL go to IDLE, clear the counter and latched op, and drive stall=0, done=0, addr_err=0, bus_err=0, load_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
REQ-034 Reset during REQ SHALL drop bus_req at that edge; a later stray bus_ack SHALL have no effect.

Verification
REQ-035 Load byte signed: addr=0x0000_1003, ack one cycle later with rdata=0x8077_0000 -> bus_addr=0x1000, bus_be=1111 (reads use full word), load_data=0xFFFF_FF80, done pulses 3 cycles after acceptance.
REQ-036 Store halfword: addr=0x0000_2002, wdata=0x1234_ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, bus_addr=0x2000, load_data=0.
REQ-037 Misaligned load word: addr=0x0000_0006 -> no bus_req, done with addr_err=1 on the next cycle, stall high for 1 cycle.
REQ-038 No ack with TIMEOUT=16 -> bus_req high 16 cycles, then done with bus_err=1; ack arriving on cycle 16 -> normal completion.
REQ-039 Reset asserted on the second REQ cycle -> bus_req=0 and stall=0 the next cycle; an ack pulse 2 cycles later -> no done.
REQ-040 Back-to-back: op_valid held continuously with two loads -> second load accepted only in the IDLE cycle after DONE, and its address never appears while the first is in REQ.
